// File: rtl/sha2_stream_core.sv
// SHA-224/256 compression core: takes 16-word blocks, chains H across blocks and holds the final digest.
// Word 15 to digest_valid is 64/ROUNDS_PER_CYCLE+1 cycles; in_ready is low outside LOAD and the digest waits for digest_ready.
module sha2_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         mode_224,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
    $error("sha2_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {LOAD, ROUND, UPDATE, DONE} state_t;

  localparam logic [5:0] STEP      = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_STEP = 6'(64 - ROUNDS_PER_CYCLE);

  // Index 7 holds H0 / a, so the 256-bit digest is the H vector itself.
  localparam logic [7:0][31:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [7:0][31:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s, input logic [31:0] kw);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kw;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t            state, state_nx;
  logic [3:0]        word_cnt;
  logic [5:0]        round_cnt;
  logic [7:0][31:0]  h, wk, st_nx, h_sum;
  logic [15:0][31:0] w, win_nx;
  logic              last_flag, mode_r;
  logic [255:0]      digest_r;

  // w[0] is always W[t]; each round appends W[t+16] so the window never needs random access.
  always_comb begin
    st_nx  = wk;
    win_nx = w;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      st_nx  = sha_round(st_nx, K[round_cnt + 6'(j)] + win_nx[0]);
      win_nx = {sig1(win_nx[14]) + win_nx[9] + sig0(win_nx[1]) + win_nx[0], win_nx[15:1]};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h[i] + wk[i];
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    digest_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && word_cnt == 4'd15) state_nx = ROUND;
      end
      ROUND:   if (round_cnt == LAST_STEP) state_nx = UPDATE;
      UPDATE:  state_nx = last_flag ? DONE : LOAD;
      DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      word_cnt  <= '0;
      round_cnt <= '0;
      h         <= IV_256;
      wk        <= '0;
      w         <= '0;
      last_flag <= 1'b0;
      mode_r    <= 1'b0;
      digest_r  <= IV_256;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (in_valid) begin
          w        <= {in_word, w[15:1]};
          word_cnt <= word_cnt + 4'd1;
          if (word_cnt == 4'd0 && in_first) begin
            h      <= mode_224 ? IV_224 : IV_256;
            mode_r <= mode_224;
          end
          if (word_cnt == 4'd15) begin
            last_flag <= in_last;
            wk        <= h;
          end
        end
        ROUND: begin
          wk        <= st_nx;
          w         <= win_nx;
          round_cnt <= round_cnt + STEP;
        end
        UPDATE: begin
          h        <= h_sum;
          digest_r <= mode_r ? {h_sum[7:1], 32'h0} : h_sum;
        end
        default: ;
      endcase
    end
  end

  assign digest = digest_r;
  assign busy   = !(state == LOAD && word_cnt == 4'd0);

endmodule

// File: tb/tb_sha2_stream_core.sv
// Drives three cores (1, 2 and 4 rounds/cycle) in lockstep with known SHA-2 vectors;
// a per-core queue of expected digests is checked whenever digest_valid rises.
module tb_sha2_stream_core;

  localparam logic [255:0] IV256  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] EMP256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMP_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

  logic         clk, rst;
  logic [31:0]  in_word;
  logic         in_valid, in_first, in_last, mode_224, digest_ready;
  logic [2:0]   rdy, dv, bsy;
  logic [255:0] dig [3];

  logic [255:0] exp_q [3][$];
  int           n_checks = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_t15 = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RP = 1 << g;
    logic prev_dv = 1'b0;

    sha2_stream_core #(.ROUNDS_PER_CYCLE(RP)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_word      (in_word),
      .in_valid     (in_valid),
      .in_ready     (rdy[g]),
      .in_first     (in_first),
      .in_last      (in_last),
      .mode_224     (mode_224),
      .digest       (dig[g]),
      .digest_valid (dv[g]),
      .digest_ready (digest_ready),
      .busy         (bsy[g])
    );

    always @(negedge clk) begin
      if (dv[g] && !prev_dv) begin
        check($sformatf("r%0d_pending", RP), 256'(exp_q[g].size() != 0), 256'(1));
        if (exp_q[g].size() != 0) begin
          check($sformatf("r%0d_digest", RP), dig[g], exp_q[g][0]);
          check($sformatf("r%0d_latency", RP), 256'(cyc - last_t15), 256'(64 / RP + 1));
          void'(exp_q[g].pop_front());
        end
      end
      prev_dv <= dv[g];
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [255:0] d);
    for (int g = 0; g < 3; g++) exp_q[g].push_back(d);
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_r%0d_in_ready", tag, g), 256'(rdy[g]), 256'(1));
      check($sformatf("%s_r%0d_dvalid", tag, g), 256'(dv[g]), 256'(0));
      check($sformatf("%s_r%0d_busy", tag, g), 256'(bsy[g]), 256'(0));
      check($sformatf("%s_r%0d_digest", tag, g), dig[g], IV256);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rdy != 3'b111 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 200) check("ready_timeout", 256'(rdy), 256'(3'b111));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 400)
      check("drain_timeout", 256'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 256'(0));
  endtask

  // Word i of a block sits at bits [511-32*i -: 32]; first/last/mode are randomised off their sampling words.
  task automatic send_block(input logic [511:0] blk, input logic first, input logic last,
                            input logic m224, input bit gaps);
    int gap;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0;
      if (gaps) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          in_word = $urandom;
          @(posedge clk); #1;
        end
      end
      wait_ready();
      in_valid = 1'b1;
      in_word  = blk[511-32*i -: 32];
      in_first = (i == 0)  ? first : 1'($urandom);
      in_last  = (i == 15) ? last  : 1'($urandom);
      mode_224 = (i == 0)  ? m224  : 1'($urandom);
      @(posedge clk); #1;
      if (i == 15 && last) last_t15 = cyc;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    clk = 1'b0; rst = 1'b1;
    in_word = '0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; mode_224 = 1'b0;
    digest_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");

    push_exp(ABC256); send_block(ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0); wait_drain();
    push_exp(ABC224); send_block(ABC_BLK, 1'b1, 1'b1, 1'b1, 1'b0); wait_drain();
    push_exp(ABC256); send_block(ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0); wait_drain();

    push_exp(TWO256);
    send_block(TWO_B1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_block(TWO_B2, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // A fresh in_first mid-message discards the partially chained H.
    push_exp(ABC256);
    send_block(TWO_B1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();

    digest_ready = 1'b0;
    push_exp(EMP256);
    send_block(EMP_BLK, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (dv != 3'b111 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reached", 256'(dv), 256'(3'b111));
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_word = $urandom; in_first = 1'b1; in_last = 1'($urandom);
      mode_224 = 1'($urandom);
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        check($sformatf("hold_r%0d_dvalid", g), 256'(dv[g]), 256'(1));
        check($sformatf("hold_r%0d_in_ready", g), 256'(rdy[g]), 256'(0));
        check($sformatf("hold_r%0d_digest", g), dig[g], EMP256);
      end
    end
    in_valid = 1'b0;
    digest_ready = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("release_r%0d_dvalid", g), 256'(dv[g]), 256'(0));
      check($sformatf("release_r%0d_in_ready", g), 256'(rdy[g]), 256'(1));
    end
    wait_drain();

    push_exp(ABC224); send_block(ABC_BLK, 1'b1, 1'b1, 1'b1, 1'b0); wait_drain();

    // Abort an in-flight hash; it must never produce a digest.
    send_block(ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("midrun_busy", 256'(bsy), 256'(3'b111));
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("postrst");

    // in_first=0 after reset continues from the reset H (SHA-256 IV, 256 mode).
    push_exp(ABC256); send_block(ABC_BLK, 1'b0, 1'b1, 1'b1, 1'b0); wait_drain();

    repeat (5) @(posedge clk);
    check("leftover_expected", 256'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sha2_stream_core.md
# sha2_stream_core

Parametrised SHA-224/SHA-256 compression core for streaming, multi-block messages. It accepts pre-padded 512-bit blocks as sixteen 32-bit words over a valid/ready handshake. It chains the intermediate hash across blocks and presents the final digest on a held valid/ready output. It is the next-generation hashing engine in the vote-integrity datapath, placed downstream of the padding/framing logic and upstream of the signature/compare stage.

## Interface
- ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4; any other value is an elaboration error.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_word  input  32  message word; word 0 of a block is the most significant (big-endian).
- in_valid  input  1  in_word valid.
- in_ready  output  1  core accepts a word this cycle.
- in_first  input  1  sampled with word 0 only; 1 = first block of a message, so reload the IV.
- in_last  input  1  sampled with word 15 only; 1 = final block of a message.
- mode_224  input  1  sampled with word 0 when in_first=1; 1 = SHA-224 IV and output.
- digest  output  256  final hash; SHA-256 = {H0..H7}; SHA-224 = {H0..H6, 32'h0}.
- digest_valid  output  1  digest valid, held until accepted.
- digest_ready  input  1  downstream accepts the digest.
- busy  output  1  high in any state other than LOAD with word count 0.

## Operation
- States: LOAD, ROUND, UPDATE, DONE. Reset enters LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word (in_valid & in_ready) shifts into a 16-entry W window and increments a 4-bit word counter.
  - On word 0 with in_first=1, H0..H7 load the IV selected by mode_224, and the mode is latched for the message.
  - On word 15, in_last is latched, working registers a..h are loaded from H, and the state moves to ROUND.
- ROUND:
  - in_ready=0.
  - Each cycle performs ROUNDS_PER_CYCLE chained rounds using K[t] and W[t].
  - For t≥16, W[t] is computed on the fly from the 16-word window: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window shifts by ROUNDS_PER_CYCLE words per cycle.
  - A round counter 0..63 steps by ROUNDS_PER_CYCLE. After round 63 the state moves to UPDATE.
- UPDATE: Hi ← Hi + working register i, modulo 2^32, for all eight words. If the latched last flag is set, go to DONE; otherwise return to LOAD.
- DONE: digest_valid=1 and digest is stable. On digest_ready, go to LOAD.
- Arithmetic: all additions are 32-bit, wrapping, with no carry out. Rotations and shifts follow FIPS 180-4.
- The IV for SHA-224 is c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4. The IV for SHA-256 is the standard 6a09e667…5be0cd19.
- Padding and length encoding are the upstream block's responsibility; the core hashes exactly the words it is given.

## Timing
- Reset values:
  - State is LOAD; word and round counters are 0.
  - in_ready=1, digest_valid=0, busy=0.
  - H is the SHA-256 IV and digest reads {SHA-256 IV}; the latched mode is 256.
  - W and a..h are 0.
- Block accept takes a minimum of 16 cycles; in_valid gaps stall the word counter without penalty.
- Latency from the word-15 accept edge to UPDATE is 64/ROUNDS_PER_CYCLE cycles (64/32/16). UPDATE takes 1 cycle.
- digest_valid rises on the edge after UPDATE. Latency from word 15 of the last block to digest_valid is 64/ROUNDS_PER_CYCLE + 1 cycles.
- Back-to-back blocks: in_ready returns to 1 on the cycle after UPDATE of a non-last block.
- DONE: in_ready=0. digest_valid falls on the edge where digest_ready=1. in_ready=1 in the following cycle. digest holds its value until the next UPDATE.
- Boundary cases:
  - in_valid outside LOAD is ignored.
  - digest_ready while digest_valid=0 is ignored.
  - in_first=1 on word 0 of any block restarts the chain from the IV, even mid-message.
  - in_first=0 on the first block after reset continues from the reset H, which is the SHA-256 IV.
  - in_first and in_last may both be 1 for a single-block message.
- Reset mid-operation: asserting rst in any state forces the reset values immediately. A partial block or in-flight digest is discarded, with no output pulse.

## Test plan
- SHA-256 of "abc" (one padded block, first=last=1), ROUNDS_PER_CYCLE=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid rises 65 cycles after the word-15 accept.
- SHA-224 of "abc" (mode_224=1) -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with random in_valid gaps, run at ROUNDS_PER_CYCLE=1, 2 and 4 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 each time. Latency after word 15 is 65/33/17 cycles.
- Empty message, with digest_ready held low for 20 cycles -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. The digest stays stable, in_ready=0, and in_valid is ignored until the handshake completes.
- rst asserted during ROUND of the first "abc" hash, then a fresh "abc" -> no digest_valid from the aborted run; the second run gives ba7816bf…f20015ad.
- Back-to-back messages ("abc" SHA-224, then "abc" SHA-256, each with in_first=1) -> correct independent digests, proving the IV and mode reload.
